// File: rtl/vga_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_pkg                                                      |
// | Description : Shared VGA timing constants (640x480 @ 60 Hz defaults) and a |
// |               helper that sizes position counters. Timing generators and   |
// |               pixel generators import this package.                        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package vga_pkg;

    // Default horizontal timing, in pixels.
    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    // Default vertical timing, in lines.
    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Both sync pulses are active-low in the standard 640x480 mode.
    localparam bit VGA_HSYNC_POL = 1'b0;
    localparam bit VGA_VSYNC_POL = 1'b0;

    localparam int VGA_CW          = 10;
    localparam int VGA_FRAME_CNT_W = 8;

    // Bits needed for a counter that runs 0..total-1.
    function automatic int vga_cw(input int total);
        return (total <= 2) ? 1 : $clog2(total);
    endfunction

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_axis_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_axis_counter                                             |
// | Description : One timing axis (horizontal or vertical). Counts 0..TOTAL-1  |
// |               while en is high and registers the sync level decoded from   |
// |               the next position so it lines up with pos.                   |
// | Ports       : clk, reset_n (sync, active-low), en (advance strobe)         |
// |               pos         - registered position                            |
// |               sync        - registered sync level (POL while in pulse)     |
// |               active_next - display-area flag for the next position        |
// |               wrap        - this edge takes pos from TOTAL-1 back to 0     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module vga_axis_counter #(
    parameter int DISPLAY = 640,
    parameter int FRONT   = 16,
    parameter int SYNC    = 96,
    parameter int BACK    = 48,
    parameter bit POL     = 1'b0,
    parameter int CW      = 10
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    output logic [CW-1:0] pos,
    output logic          sync,
    output logic          active_next,
    output logic          wrap
);

    localparam int            TOTAL      = DISPLAY + FRONT + SYNC + BACK;
    localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
    localparam logic [CW-1:0] DISP_END   = CW'(DISPLAY);
    localparam logic [CW-1:0] SYNC_FIRST = CW'(DISPLAY + FRONT);
    localparam logic [CW-1:0] SYNC_LAST  = CW'(DISPLAY + FRONT + SYNC - 1);

    logic [CW-1:0] pos_next;
    logic          sync_next;

    assign wrap = en && (pos == LAST);

    always_comb begin
        pos_next = pos;
        if (en) begin
            pos_next = wrap ? '0 : pos + CW'(1);
        end
    end

    // Decoding from pos_next (rather than pos) keeps the registered level
    // outputs in the same cycle as the registered position.
    assign active_next = (pos_next < DISP_END);
    assign sync_next   = ((pos_next >= SYNC_FIRST) && (pos_next <= SYNC_LAST)) ? POL : ~POL;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pos  <= '0;
            sync <= ~POL;
        end else begin
            pos  <= pos_next;
            sync <= sync_next;
        end
    end

endmodule : vga_axis_counter
`default_nettype wire

// File: rtl/vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : vga_timing_gen                                               |
// | Description : VGA raster timing generator. Produces pixel position, active |
// |               video flag, sync pulses, line/frame start pulses and a frame |
// |               counter. Everything advances only on pix_en strobes and all  |
// |               outputs are registered with zero relative skew.              |
// | Ports       : clk, reset_n (sync, active-low), pix_en (pixel strobe)       |
// |               pixel_x/pixel_y, video_on, hsync, vsync,                     |
// |               line_start, frame_start, frame_cnt                           |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK,
    parameter bit HSYNC_POL = VGA_HSYNC_POL,
    parameter bit VSYNC_POL = VGA_VSYNC_POL,
    parameter int CW        = VGA_CW
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       pix_en,
    output logic [CW-1:0]              pixel_x,
    output logic [CW-1:0]              pixel_y,
    output logic                       video_on,
    output logic                       hsync,
    output logic                       vsync,
    output logic                       line_start,
    output logic                       frame_start,
    output logic [VGA_FRAME_CNT_W-1:0] frame_cnt
);

    logic h_active_next;
    logic h_wrap;
    logic v_active_next;
    logic v_wrap;
    logic frame_wrap;

    vga_axis_counter #(
        .DISPLAY (H_DISPLAY),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .POL     (HSYNC_POL),
        .CW      (CW)
    ) u_h_axis (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (pix_en),
        .pos         (pixel_x),
        .sync        (hsync),
        .active_next (h_active_next),
        .wrap        (h_wrap)
    );

    // h_wrap already includes pix_en, so the vertical axis steps exactly
    // once per completed line.
    vga_axis_counter #(
        .DISPLAY (V_DISPLAY),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .POL     (VSYNC_POL),
        .CW      (CW)
    ) u_v_axis (
        .clk         (clk),
        .reset_n     (reset_n),
        .en          (h_wrap),
        .pos         (pixel_y),
        .sync        (vsync),
        .active_next (v_active_next),
        .wrap        (v_wrap)
    );

    assign frame_wrap = h_wrap && v_wrap;

    // Pulses are recomputed every clk, so they last exactly one clk even
    // when pix_en is low in the following cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            video_on    <= 1'b1;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            video_on    <= h_active_next && v_active_next;
            line_start  <= h_wrap;
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + VGA_FRAME_CNT_W'(1);
            end
        end
    end

endmodule : vga_timing_gen
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_vga_timing_gen                                            |
// | Description : Self-checking bench for vga_timing_gen using a reduced       |
// |               raster so full frames and frame-counter wrap stay short.     |
// |               Expected outputs come from a linear-pixel-index model.       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_vga_timing_gen;

    localparam int HD = 8, HF = 2, HS = 3, HB = 2;
    localparam int VD = 6, VF = 1, VS = 2, VB = 2;
    localparam bit HP = 1'b1;
    localparam bit VP = 1'b0;
    localparam int CW = 4;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int FT = HT * VT;
    localparam int VW = 2 * CW + 13;

    logic          clk     = 1'b0;
    logic          reset_n = 1'b0;
    logic          pix_en  = 1'b0;
    logic [CW-1:0] pixel_x;
    logic [CW-1:0] pixel_y;
    logic          video_on;
    logic          hsync;
    logic          vsync;
    logic          line_start;
    logic          frame_start;
    logic [7:0]    frame_cnt;
    logic [VW-1:0] act_vec;

    int checks = 0;
    int errors = 0;

    // Reference model: linear index into the raster, frame count, pulses.
    int m_p  = 0;
    int m_fc = 0;
    bit m_ls = 1'b0;
    bit m_fs = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_DISPLAY (HD), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_DISPLAY (VD), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .HSYNC_POL (HP), .VSYNC_POL (VP), .CW (CW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pix_en      (pix_en),
        .pixel_x     (pixel_x),
        .pixel_y     (pixel_y),
        .video_on    (video_on),
        .hsync       (hsync),
        .vsync       (vsync),
        .line_start  (line_start),
        .frame_start (frame_start),
        .frame_cnt   (frame_cnt)
    );

    assign act_vec = {pixel_x, pixel_y, video_on, hsync, vsync, line_start, frame_start, frame_cnt};

    function automatic logic [VW-1:0] exp_vec();
        int   x = m_p % HT;
        int   y = m_p / HT;
        logic v;
        logic h;
        logic s;
        v = (x < HD) && (y < VD);
        h = (x >= HD + HF && x < HD + HF + HS) ? HP : ~HP;
        s = (y >= VD + VF && y < VD + VF + VS) ? VP : ~VP;
        return {CW'(x), CW'(y), v, h, s, m_ls, m_fs, 8'(m_fc)};
    endfunction

    // Advance one clock and update the model from the inputs seen at that edge.
    task automatic tick();
        @(posedge clk);
        if (!reset_n) begin
            m_p = 0; m_fc = 0; m_ls = 1'b0; m_fs = 1'b0;
        end else if (pix_en) begin
            m_ls = (m_p % HT == HT - 1);
            m_fs = (m_p == FT - 1);
            m_p  = (m_p + 1) % FT;
            if (m_fs) m_fc = (m_fc + 1) % 256;
        end else begin
            m_ls = 1'b0; m_fs = 1'b0;
        end
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pix_en = 1'($urandom % 2);
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL reset_state act=%h exp=%h", act_vec, exp_vec());
            end
        end
        checks++;
        if (pixel_x !== '0 || pixel_y !== '0 || video_on !== 1'b1 || hsync !== ~HP ||
            vsync !== ~VP || frame_cnt !== 8'd0 || line_start !== 1'b0 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL reset_values act=%h exp x=0 y=0 v=1 h=%b vs=%b 0 0 0", act_vec, ~HP, ~VP);
        end
    endtask

    task automatic test_free_run();
        int n_vid = 0, n_ls = 0, n_fs = 0, n_hs = 0, n_vs = 0;
        int fc0;
        reset_n = 1'b1;
        pix_en  = 1'b1;
        fc0 = m_fc;
        for (int i = 0; i < FT; i++) begin
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL free_run act=%h exp=%h", act_vec, exp_vec());
            end
            n_vid += int'(video_on === 1'b1);
            n_ls  += int'(line_start === 1'b1);
            n_fs  += int'(frame_start === 1'b1);
            n_hs  += int'(hsync === HP);
            n_vs  += int'(vsync === VP);
        end
        checks++;
        if (n_vid != HD * VD || n_ls != VT || n_fs != 1 || n_hs != HS * VT || n_vs != VS * HT) begin
            errors++;
            $display("FAIL frame_counts vid=%0d ls=%0d fs=%0d hs=%0d vs=%0d exp %0d %0d 1 %0d %0d",
                     n_vid, n_ls, n_fs, n_hs, n_vs, HD * VD, VT, HS * VT, VS * HT);
        end
        checks++;
        if (frame_cnt !== 8'((fc0 + 1) % 256)) begin
            errors++;
            $display("FAIL frame_cnt_inc act=%0d exp=%0d", frame_cnt, (fc0 + 1) % 256);
        end
    endtask

    task automatic test_pix_en_toggle();
        int first = -1, second = -1, ls_prev = 0;
        reset_n = 1'b0; pix_en = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 1; i <= 6 * FT && second < 0; i++) begin
            pix_en = 1'(i % 2);
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL toggle act=%h exp=%h", act_vec, exp_vec());
            end
            if (ls_prev != 0 && line_start === 1'b1) begin
                checks++;
                errors++;
                $display("FAIL line_start_width act=2 exp=1");
            end
            ls_prev = int'(line_start === 1'b1);
            if (frame_start === 1'b1) begin
                if (first < 0) first = i;
                else second = i;
            end
        end
        checks++;
        if (first < 0 || second < 0 || second - first != 2 * FT) begin
            errors++;
            $display("FAIL toggle_frame_len act=%0d exp=%0d", second - first, 2 * FT);
        end
    endtask

    task automatic test_mid_reset();
        reset_n = 1'b0; pix_en = 1'b1;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < FT + 4 * HT + 9; i++) tick();
        checks++;
        if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL mid_position act=%h exp=%h", act_vec, exp_vec());
        end
        reset_n = 1'b0;
        tick();
        checks++;
        if (pixel_x !== '0 || pixel_y !== '0 || video_on !== 1'b1 || frame_cnt !== 8'd0 ||
            frame_start !== 1'b0 || act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL mid_reset act=%h exp=%h", act_vec, exp_vec());
        end
        reset_n = 1'b1; pix_en = 1'b0;
        tick();
        checks++;
        if (act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_hold act=%h exp=%h", act_vec, exp_vec());
        end
        pix_en = 1'b1;
        tick();
        checks++;
        if (pixel_x !== CW'(1) || pixel_y !== '0 || act_vec !== exp_vec()) begin
            errors++;
            $display("FAIL resume act=%h exp=%h", act_vec, exp_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            pix_en  = 1'($urandom % 2);
            reset_n = ($urandom % 250) != 0;
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random act=%h exp=%h", act_vec, exp_vec());
            end
        end
    endtask

    task automatic test_frame_wrap();
        bit saw_wrap = 1'b0;
        reset_n = 1'b0; pix_en = 1'b1;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 256 * FT; i++) begin
            tick();
            checks++;
            if (act_vec !== exp_vec()) begin
                errors++;
                $display("FAIL frame_wrap act=%h exp=%h", act_vec, exp_vec());
            end
            if (frame_start === 1'b1 && frame_cnt === 8'd0) saw_wrap = 1'b1;
        end
        checks++;
        if (!saw_wrap || frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL cnt_wrap act=%0d saw=%b exp=0 saw=1", frame_cnt, saw_wrap);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_pix_en_toggle();
        test_mid_reset();
        test_random();
        test_frame_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vga_timing_gen
`default_nettype wire
